// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding and the
// default stage indices of the six-stage core.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam int NUM_STAGES_DEF = STG_WB + 1;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// Highest-set-bit encoder: every stage at or below the topmost requester
// holds, and the stage just above it takes a bubble.
module pipe_ctrl_prio #(
  parameter int STAGES = 6
) (
  input  logic [STAGES-1:0] req,
  output logic [STAGES-1:0] stall_mask,
  output logic [STAGES-1:0] bubble
);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_mask
      assign stall_mask[gi] = |req[STAGES-1:gi];
    end

    assign bubble[0] = 1'b0;
    // The bubble sits exactly on the first stage that is not held.
    for (gi = 1; gi < STAGES; gi++) begin : g_bubble
      assign bubble[gi] = stall_mask[gi-1] & ~stall_mask[gi];
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage stall/flush generator with a branch/trap redirect sequencer.
// Optional stall watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES   = NUM_STAGES_DEF,
  parameter int ADDR_W   = 32,
  parameter int BR_STAGE = STG_EX,
  parameter int WDOG_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  output logic              br_ack_o,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  output logic              trap_ack_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  input  logic              redirect_ready_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  output logic              wdog_o
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [STAGES-1:0] prio_req, prio_stall, prio_bubble;
  logic [STAGES-1:0] mid_mask, late_mask, low_mask;
  logic              late_clear, br_accept, trap_take;

  genvar gi;
  generate
    if ((BR_STAGE < 1) || (BR_STAGE > STAGES - 2) || (WDOG_W < 1)) begin : g_param_check
      $error("pipe_ctrl: illegal BR_STAGE/STAGES/WDOG_W combination");
    end
    for (gi = 0; gi < STAGES; gi++) begin : g_masks
      assign mid_mask[gi]  = (gi >= 1) && (gi < BR_STAGE);
      assign late_mask[gi] = (gi > BR_STAGE);
      assign low_mask[gi]  = (gi <= STAGES - 2);
    end
  endgenerate

  // DRAIN and REDIRECT hold fixed stages; folding that into the request
  // vector keeps the bubble placed just above whatever ends up held.
  always_comb begin
    prio_req = stallreq_i;
    if (state_reg == ST_DRAIN)    prio_req[BR_STAGE] = 1'b1;
    if (state_reg == ST_REDIRECT) prio_req[0]        = 1'b1;
  end

  pipe_ctrl_prio #(.STAGES(STAGES)) u_prio (
    .req        (prio_req),
    .stall_mask (prio_stall),
    .bubble     (prio_bubble)
  );

  assign late_clear = (stallreq_i & late_mask) == '0;
  assign br_accept  = !rst && (state_reg == ST_IDLE) && br_valid_i && !trap_req_i
                      && !prio_stall[BR_STAGE];
  assign trap_take  = !rst && (state_reg == ST_DRAIN) && late_clear;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    stall_o    = prio_stall;
    flush_o    = prio_bubble;
    case (state_reg)
      ST_IDLE: begin
        if (trap_req_i) begin
          state_next = ST_DRAIN;
        end else if (br_accept) begin
          // Younger stages are killed, so their stall requests no longer matter.
          stall_o    = '0;
          flush_o    = mid_mask;
          addr_next  = br_addr_i;
          state_next = ST_REDIRECT;
        end
      end
      ST_DRAIN: begin
        if (late_clear) begin
          flush_o    = low_mask;
          addr_next  = trap_addr_i;
          state_next = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        flush_o = prio_bubble | mid_mask;
        if (redirect_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (rst) begin
      stall_o = '0;
      flush_o = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  assign br_ack_o         = br_accept;
  assign trap_ack_o       = trap_take;
  assign redirect_valid_o = !rst && (state_reg == ST_REDIRECT);
  assign redirect_addr_o  = rst ? '0 : addr_reg;

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              wdog_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      wdog_reg     <= 1'b0;
    end else if (stall_o == '0) begin
      wdog_cnt_reg <= '0;
    end else begin
      if (wdog_cnt_reg != WDOG_MAX) wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      if (wdog_cnt_reg == WDOG_MAX - 1'b1) wdog_reg <= 1'b1;
    end
  end

  assign wdog_o = wdog_reg && !rst;
`else
  assign wdog_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised self-checking bench for pipe_ctrl against a cycle-level model
// derived from the controller's stall, branch, trap and redirect rules.
module tb_pipe_ctrl;

  localparam int ST = 6;
  localparam int BR = 3;
  localparam int AW = 32;
  localparam int WW = 4;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_REDIR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ST-1:0] stallreq = '0;
  logic          br_valid = 1'b0, trap_req = 1'b0, ready = 1'b0;
  logic [AW-1:0] br_addr = '0, trap_addr = '0;
  logic          br_ack_o, trap_ack_o, redirect_valid_o, wdog_o;
  logic [AW-1:0] redirect_addr_o;
  logic [ST-1:0] stall_o, flush_o;

  int vectors = 0;
  int miscompares = 0;

  pipe_ctrl #(.STAGES(ST), .ADDR_W(AW), .BR_STAGE(BR), .WDOG_W(WW)) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .br_valid_i(br_valid),
    .br_addr_i(br_addr), .br_ack_o(br_ack_o), .trap_req_i(trap_req),
    .trap_addr_i(trap_addr), .trap_ack_o(trap_ack_o),
    .redirect_valid_o(redirect_valid_o), .redirect_addr_o(redirect_addr_o),
    .redirect_ready_i(ready), .stall_o(stall_o), .flush_o(flush_o), .wdog_o(wdog_o)
  );

  always #5 clk = ~clk;

  // Model state (current and next), advanced once per clock.
  int            m_mode = M_IDLE, nx_mode = M_IDLE;
  logic [AW-1:0] m_addr = '0, nx_addr = '0;
  int            m_cnt = 0, nx_cnt = 0;
  logic          m_wdog = 1'b0, nx_wdog = 1'b0;
  logic [47:0]   exp_vec;
  logic          exp_tra;

  function automatic logic [47:0] obs();
    return {stall_o, flush_o, br_ack_o, trap_ack_o, redirect_valid_o, redirect_addr_o, wdog_o};
  endfunction

  task automatic model_eval();
    int top, eff;
    logic [ST-1:0] s, f, mid, lowf;
    logic bra, tra, val, ew;
    mid  = ST'(((1 << BR) - 1) & ~1);
    lowf = ST'((1 << (ST - 1)) - 1);
    top = -1;
    for (int k = 0; k < ST; k++) if (stallreq[k]) top = k;
    eff = top;
    if (m_mode == M_DRAIN && eff < BR) eff = BR;
    if (m_mode == M_REDIR && eff < 0) eff = 0;
    s = (eff >= 0) ? ST'((1 << (eff + 1)) - 1) : '0;
    f = (eff >= 0 && eff + 1 < ST) ? ST'(1 << (eff + 1)) : '0;
    bra = 1'b0; tra = 1'b0; val = (m_mode == M_REDIR);
    nx_mode = m_mode; nx_addr = m_addr;
    if (m_mode == M_IDLE) begin
      if (trap_req) nx_mode = M_DRAIN;
      else if (br_valid && top < BR) begin
        bra = 1'b1; s = '0; f = mid; nx_addr = br_addr; nx_mode = M_REDIR;
      end
    end else if (m_mode == M_DRAIN) begin
      if ((stallreq >> (BR + 1)) == 0) begin
        tra = 1'b1; f = lowf; nx_addr = trap_addr; nx_mode = M_REDIR;
      end
    end else begin
      f = f | mid;
      if (ready) nx_mode = M_IDLE;
    end
    nx_cnt = (s == 0) ? 0 : ((m_cnt < (1 << WW) - 1) ? m_cnt + 1 : m_cnt);
    nx_wdog = m_wdog | (nx_cnt == (1 << WW) - 1);
`ifdef PIPE_CTRL_WDOG_EN
    ew = m_wdog;
`else
    ew = 1'b0;
`endif
    if (rst) begin
      s = '0; f = '1; bra = 1'b0; tra = 1'b0; val = 1'b0; ew = 1'b0;
      nx_mode = M_IDLE; nx_addr = '0; nx_cnt = 0; nx_wdog = 1'b0;
    end
    exp_tra = tra;
    exp_vec = {s, f, bra, tra, val, (rst ? {AW{1'b0}} : m_addr), ew};
  endtask

  task automatic cycle(input logic r, input logic [ST-1:0] sr, input logic bv,
                       input logic [AW-1:0] ba, input logic tr, input logic [AW-1:0] ta,
                       input logic rdy);
    @(negedge clk);
    m_mode = nx_mode; m_addr = nx_addr; m_cnt = nx_cnt; m_wdog = nx_wdog;
    rst = r; stallreq = sr; br_valid = bv; br_addr = ba;
    trap_req = tr; trap_addr = ta; ready = rdy;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 6'($urandom), 1'b1, 32'h1234, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
    end
    vectors++;
    if (flush_o !== 6'b111111 || stall_o !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_values stall=%b flush=%b exp stall=000000 flush=111111", stall_o, flush_o);
    end
  endtask

  task automatic test_stall_prio();
    cycle(1'b0, 6'b010000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (stall_o !== 6'b011111 || flush_o !== 6'b100000) begin
      miscompares++;
      $display("FAIL stall_mem stall=%b flush=%b exp 011111/100000", stall_o, flush_o);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 6'($urandom), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++;
        $display("FAIL stall_rand cyc=%0d req=%b got=%h exp=%h", i, stallreq, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_branch();
    cycle(1'b0, 6'b000000, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (br_ack_o !== 1'b1 || flush_o !== 6'b000110 || obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL branch_accept ack=%b flush=%b got=%h exp=%h", br_ack_o, flush_o, obs(), exp_vec);
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (redirect_valid_o !== 1'b1 || redirect_addr_o !== 32'h80 || obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL branch_redirect valid=%b addr=%h exp 1/00000080", redirect_valid_o, redirect_addr_o);
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (redirect_valid_o !== 1'b0 || obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL branch_done valid=%b exp 0", redirect_valid_o);
    end
  endtask

  task automatic test_redirect_hold();
    logic [AW-1:0] a;
    a = $urandom;
    cycle(1'b0, 6'b000000, 1'b1, a, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'b000000, 1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (redirect_valid_o !== 1'b1 || redirect_addr_o !== a || stall_o[0] !== 1'b1
          || br_ack_o !== 1'b0 || obs() !== exp_vec) begin
        miscompares++;
        $display("FAIL redirect_hold cyc=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL redirect_release got=%h exp=%h", obs(), exp_vec);
    end
  endtask

  task automatic test_trap();
    int ack_at = -1;
    logic [AW-1:0] ta;
    ta = $urandom;
    for (int i = 0; i < 10 && ack_at < 0; i++) begin
      cycle(1'b0, (i < 2) ? 6'b010000 : 6'b000000, 1'b0, 32'h0, 1'b1, ta, 1'b1);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++;
        $display("FAIL trap_seq cyc=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
      if (trap_ack_o === 1'b1) begin
        ack_at = i;
        vectors++;
        if (flush_o !== 6'b011111) begin
          miscompares++;
          $display("FAIL trap_flush flush=%b exp 011111", flush_o);
        end
      end
    end
    vectors++;
    if (ack_at != 2) begin
      miscompares++;
      $display("FAIL trap_latency ack_cycle=%0d exp 2", ack_at);
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (redirect_valid_o !== 1'b1 || redirect_addr_o !== ta) begin
      miscompares++;
      $display("FAIL trap_redirect valid=%b addr=%h exp 1/%h", redirect_valid_o, redirect_addr_o, ta);
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_trap_vs_branch();
    logic [AW-1:0] ta;
    logic seen = 1'b0;
    ta = $urandom;
    cycle(1'b0, 6'b000000, 1'b1, 32'hBEEF, 1'b1, ta, 1'b1);
    vectors++;
    if (br_ack_o !== 1'b0 || obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL trap_vs_branch ack=%b exp 0", br_ack_o);
    end
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle(1'b0, 6'b000000, 1'b1, 32'hBEEF, 1'b1, ta, 1'b1);
      if (trap_ack_o === 1'b1) seen = 1'b1;
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (!seen || redirect_addr_o !== ta || redirect_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL trap_wins seen=%b addr=%h exp %h", seen, redirect_addr_o, ta);
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    logic [AW-1:0] ta = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold && $urandom_range(0, 15) == 0) begin hold = 1'b1; ta = $urandom; end
      cycle(1'b0, ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0,
            1'($urandom_range(0, 1)), $urandom, hold, ta, ($urandom_range(0, 2) != 0));
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
      if (hold && exp_tra) hold = 1'b0;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_wdog_and_reset();
    logic exp_w;
    cycle(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 6'b000001, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++;
        $display("FAIL wdog_run cyc=%0d got=%h exp=%h", i, obs(), exp_vec);
      end
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef PIPE_CTRL_WDOG_EN
    exp_w = 1'b1;
`else
    exp_w = 1'b0;
`endif
    vectors++;
    if (wdog_o !== exp_w || obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL wdog_sticky got=%b exp=%b", wdog_o, exp_w);
    end
    cycle(1'b0, 6'b000000, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (redirect_valid_o !== 1'b1 || obs() !== exp_vec) begin
      miscompares++;
      $display("FAIL pre_reset_redirect got=%h exp=%h", obs(), exp_vec);
    end
    cycle(1'b1, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs() !== exp_vec || flush_o !== 6'b111111 || redirect_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_redirect got=%h exp=%h", obs(), exp_vec);
    end
    cycle(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs() !== exp_vec || redirect_valid_o !== 1'b0 || redirect_addr_o !== 32'h0 || wdog_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got=%h exp=%h", obs(), exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_stall_prio();
    test_branch();
    test_redirect_hold();
    test_trap();
    test_trap_vs_branch();
    test_random();
    test_wdog_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
